mem_bus_decoder: RTL and testbench

//   Parametrised address decoder and response mux for the picorv32 native memory bus.
//   - Replaces hand-written per-SoC chip-select and ready logic with a table of N slave windows.
//   - Latency is set per slave: a fixed wait-state count, or ready driven by the slave itself.
//   - Adds a watchdog timeout and unmapped-address error response, both reported on bus_err/err_addr.
//   - Sits between the CPU and all memory-mapped peripherals (ROM, RAM, char RAM, LED, UART, ...).

---
 rtl/mem_bus_pkg.sv | 30 +++
 rtl/mem_bus_match.sv | 34 +++
 rtl/mem_bus_decoder.sv | 133 +++++++++++++
 tb/tb_mem_bus_decoder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types, widths and window-table accessors for the memory bus decoder.
package mem_bus_pkg;

  localparam int CNT_W      = 8;
  localparam int LAT_W      = 4;
  localparam int IDX_W      = 4;
  localparam int MAX_SLAVES = 16;
  localparam int ADDR_TBL_W = 32 * MAX_SLAVES;
  localparam int LAT_TBL_W  = LAT_W * MAX_SLAVES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } bus_state_t;

  // Tables are zero-extended to the 16-slave maximum so one signature serves every N.
  function automatic logic [31:0] base_of(input logic [ADDR_TBL_W-1:0] tbl, input int i);
    return tbl[32*i +: 32];
  endfunction

  function automatic logic [31:0] mask_of(input logic [ADDR_TBL_W-1:0] tbl, input int i);
    return tbl[32*i +: 32];
  endfunction

  function automatic logic [LAT_W-1:0] lat_of(input logic [LAT_TBL_W-1:0] tbl, input int i);
    return tbl[LAT_W*i +: LAT_W];
  endfunction

endpackage

// File: rtl/mem_bus_match.sv
// Combinational window compare across all slaves; overlapping windows resolve to the lowest index.
module mem_bus_match
  import mem_bus_pkg::*;
#(
  parameter int                     N_SLAVES = 5,
  parameter logic [32*N_SLAVES-1:0] BASE     = {N_SLAVES{32'h0}},
  parameter logic [32*N_SLAVES-1:0] MASK     = {N_SLAVES{32'hF000}},
  parameter logic [4*N_SLAVES-1:0]  LATENCY  = {N_SLAVES{4'd1}}
) (
  input  logic [31:0]      mem_addr,
  output logic             hit,
  output logic [IDX_W-1:0] idx,
  output logic [LAT_W-1:0] lat
);

  localparam logic [ADDR_TBL_W-1:0] BASE_X = ADDR_TBL_W'(BASE);
  localparam logic [ADDR_TBL_W-1:0] MASK_X = ADDR_TBL_W'(MASK);
  localparam logic [LAT_TBL_W-1:0]  LAT_X  = LAT_TBL_W'(LATENCY);

  // Scanning from the top down lets the lowest matching index overwrite the rest.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    lat = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((mem_addr & mask_of(MASK_X, i)) == base_of(BASE_X, i)) begin
        hit = 1'b1;
        idx = IDX_W'(i);
        lat = lat_of(LAT_X, i);
      end
    end
  end

endmodule

// File: rtl/mem_bus_decoder.sv
// Address decoder and response mux for the picorv32 native bus, with per-slave latency,
// watchdog timeout and unmapped-address error reporting.
//
//   state | meaning
//   IDLE  | waiting for mem_valid; first request cycle, cnt = 0
//   BUSY  | request outstanding, cnt counts cycles since the request
//   DONE  | single dead cycle after mem_ready, blocks stale ready
module mem_bus_decoder
  import mem_bus_pkg::*;
#(
  parameter int                     N_SLAVES = 5,
  parameter logic [32*N_SLAVES-1:0] BASE     = {N_SLAVES{32'h0}},
  parameter logic [32*N_SLAVES-1:0] MASK     = {N_SLAVES{32'hF000}},
  parameter logic [4*N_SLAVES-1:0]  LATENCY  = {N_SLAVES{4'd1}},
  parameter logic [CNT_W-1:0]       TIMEOUT  = 8'd255,
  parameter logic [31:0]            ERR_DATA = 32'hDEADBEEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mem_valid,
  input  logic [31:0]              mem_addr,
  input  logic [3:0]               mem_wstrb,
  output logic                     mem_ready,
  output logic [31:0]              mem_rdata,
  output logic [N_SLAVES-1:0]      s_sel,
  output logic [N_SLAVES-1:0]      s_start,
  output logic [4*N_SLAVES-1:0]    s_wstrb,
  input  logic [N_SLAVES-1:0]      s_ready,
  input  logic [32*N_SLAVES-1:0]   s_rdata,
  output logic                     bus_err,
  output logic [31:0]              err_addr
);

  bus_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             hit;
  logic [IDX_W-1:0] idx;
  logic [LAT_W-1:0] lat;
  logic             active;
  logic             slave_ready;
  logic [31:0]      slave_rdata;
  logic             norm_ready;
  logic             err_done;
  logic             done;

  mem_bus_match #(
    .N_SLAVES (N_SLAVES),
    .BASE     (BASE),
    .MASK     (MASK),
    .LATENCY  (LATENCY)
  ) u_match (
    .mem_addr (mem_addr),
    .hit      (hit),
    .idx      (idx),
    .lat      (lat)
  );

  always_comb begin
    slave_ready = 1'b0;
    slave_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (idx == IDX_W'(i)) begin
        slave_ready = s_ready[i];
        slave_rdata = s_rdata[32*i +: 32];
      end
    end
  end

  // Gating with rst_n keeps a reset that lands on a completion cycle from leaking mem_ready.
  assign active = rst_n && mem_valid && (state == IDLE || state == BUSY);

  always_comb begin
    norm_ready = 1'b0;
    err_done   = 1'b0;
    if (active) begin
      if (hit) begin
        norm_ready = (lat == '0) ? slave_ready : (cnt == CNT_W'(lat));
        err_done   = !norm_ready && (cnt == TIMEOUT);
      end else begin
        err_done = (cnt == CNT_W'(1));
      end
    end
    done = norm_ready || err_done;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      err_addr <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (err_done) err_addr <= mem_addr;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    unique case (state)
      IDLE, BUSY: begin
        if (!active) begin
          state_nxt = IDLE;
        end else if (done) begin
          state_nxt = DONE;
        end else begin
          state_nxt = BUSY;
          cnt_nxt   = (cnt >= TIMEOUT) ? TIMEOUT : cnt + CNT_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_ready = done;
    bus_err   = err_done;
    mem_rdata = err_done ? ERR_DATA : (norm_ready ? slave_rdata : 32'h0);
    s_sel     = '0;
    s_start   = '0;
    s_wstrb   = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (active && hit && idx == IDX_W'(i)) begin
        s_sel[i]          = 1'b1;
        s_start[i]        = (state == IDLE);
        s_wstrb[4*i +: 4] = mem_wstrb;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_decoder.sv
// Randomized bench for mem_bus_decoder: transactions are predicted from the window table and
// latency/timeout rules, then compared cycle by cycle.
module tb_mem_bus_decoder;

  localparam int N   = 5;
  localparam int TMO = 6;
  localparam logic [32*N-1:0] P_BASE = {32'h0000_4000, 32'h0000_3000, 32'h0000_2000,
                                        32'h0000_0000, 32'h0000_0000};
  localparam logic [32*N-1:0] P_MASK = {32'h0000_F000, 32'h0000_F000, 32'h0000_F000,
                                        32'h0000_E000, 32'h0000_F000};
  localparam logic [4*N-1:0]  P_LAT  = {4'd0, 4'd7, 4'd3, 4'd2, 4'd1};

  // ROM, RAM (overlaps ROM), char RAM, LED (slower than the watchdog), UART (slave-ready)
  int unsigned m_base [N] = '{32'h0000, 32'h0000, 32'h2000, 32'h3000, 32'h4000};
  int unsigned m_mask [N] = '{32'hF000, 32'hE000, 32'hF000, 32'hF000, 32'hF000};
  int          m_lat  [N] = '{1, 2, 3, 7, 0};

  logic            clk = 1'b0;
  logic            rst_n;
  logic            mem_valid;
  logic [31:0]     mem_addr;
  logic [3:0]      mem_wstrb;
  logic            mem_ready;
  logic [31:0]     mem_rdata;
  logic [N-1:0]    s_sel;
  logic [N-1:0]    s_start;
  logic [4*N-1:0]  s_wstrb;
  logic [N-1:0]    s_ready;
  logic [32*N-1:0] s_rdata;
  logic            bus_err;
  logic [31:0]     err_addr;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] exp_err_addr = 32'h0;

  always #5 clk = ~clk;

  mem_bus_decoder #(
    .N_SLAVES (N),
    .BASE     (P_BASE),
    .MASK     (P_MASK),
    .LATENCY  (P_LAT),
    .TIMEOUT  (8'(TMO)),
    .ERR_DATA (32'hDEADBEEF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .s_sel     (s_sel),
    .s_start   (s_start),
    .s_wstrb   (s_wstrb),
    .s_ready   (s_ready),
    .s_rdata   (s_rdata),
    .bus_err   (bus_err),
    .err_addr  (err_addr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int decode(input logic [31:0] addr);
    for (int i = 0; i < N; i++)
      if ((addr & m_mask[i]) == m_base[i]) return i;
    return -1;
  endfunction

  // Holds mem_valid until the predicted completion, then checks the dead cycle with a stale ready.
  task automatic run_txn(input logic [31:0] addr, input logic [3:0] wstrb, input int rdy_dly);
    int          hit_i;
    int          lat_eff;
    int          t_done;
    bit          is_err;
    logic [31:0] rd [N];
    logic [31:0] exp_rd;
    logic [N-1:0]   exp_sel;
    logic [4*N-1:0] exp_ws;
    hit_i   = decode(addr);
    lat_eff = 0;
    if (hit_i < 0) begin
      is_err = 1'b1;
      t_done = 1;
    end else begin
      lat_eff = (m_lat[hit_i] == 0) ? rdy_dly : m_lat[hit_i];
      is_err  = (lat_eff > TMO);
      t_done  = is_err ? TMO : lat_eff;
    end
    for (int i = 0; i < N; i++) rd[i] = $urandom;
    exp_rd  = is_err ? 32'hDEADBEEF : rd[hit_i];
    exp_sel = (hit_i >= 0) ? (N'(1) << hit_i) : '0;
    exp_ws  = '0;
    for (int i = 0; i < N; i++) if (exp_sel[i]) exp_ws[4*i +: 4] = wstrb;
    for (int c = 0; c <= t_done; c++) begin
      @(negedge clk);
      mem_valid = 1'b1;
      mem_addr  = addr;
      mem_wstrb = wstrb;
      for (int i = 0; i < N; i++) s_rdata[32*i +: 32] = rd[i];
      s_ready    = N'($urandom);
      s_ready[4] = (c >= rdy_dly);
      #1;
      check("mem_ready", 64'(mem_ready), 64'(c == t_done));
      check("s_sel",     64'(s_sel),     64'(exp_sel));
      check("s_start",   64'(s_start),   (c == 0) ? 64'(exp_sel) : 64'h0);
      check("s_wstrb",   64'(s_wstrb),   64'(exp_ws));
      check("bus_err",   64'(bus_err),   64'((c == t_done) && is_err));
      check("mem_rdata", 64'(mem_rdata), (c == t_done) ? 64'(exp_rd) : 64'h0);
    end
    if (is_err) exp_err_addr = addr;
    @(negedge clk);
    s_ready = '1;
    #1;
    check("done_ready",  64'(mem_ready), 64'h0);
    check("done_sel",    64'(s_sel),     64'h0);
    check("done_start",  64'(s_start),   64'h0);
    check("done_err",    64'(bus_err),   64'h0);
    check("err_addr",    64'(err_addr),  64'(exp_err_addr));
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    mem_valid = 1'b0;
    s_ready   = '0;
    #1;
    check("idle_ready", 64'(mem_ready), 64'h0);
    check("idle_sel",   64'(s_sel),     64'h0);
  endtask

  initial begin
    logic [31:0] a;
    rst_n     = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wstrb = '0;
    s_ready   = '0;
    s_rdata   = '0;
    repeat (3) @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = 32'h10;
    s_ready   = '1;
    #1;
    check("rst_ready",    64'(mem_ready), 64'h0);
    check("rst_sel",      64'(s_sel),     64'h0);
    check("rst_rdata",    64'(mem_rdata), 64'h0);
    check("rst_err",      64'(bus_err),   64'h0);
    check("rst_err_addr", 64'(err_addr),  64'h0);
    @(negedge clk);
    mem_valid = 1'b0;
    rst_n     = 1'b1;

    run_txn(32'h0000_0010, 4'h0, 0);
    idle_cycle();
    run_txn(32'h0000_4008, 4'hF, 5);
    run_txn(32'h0000_9000, 4'h0, 0);
    run_txn(32'h0000_4010, 4'h0, 1000);
    run_txn(32'h0000_3000, 4'h3, 0);
    run_txn(32'h0000_1004, 4'h5, 0);
    run_txn(32'h0000_0FFC, 4'h0, 0);
    run_txn(32'h0000_0020, 4'h0, 0);
    run_txn(32'h0000_0024, 4'h0, 0);
    run_txn(32'h0000_4000, 4'h1, 0);
    run_txn(32'h0000_4004, 4'h0, TMO);

    // Dropped request: no response, and the next transfer counts from zero again.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      mem_valid = 1'b1;
      mem_addr  = 32'h0000_2040;
      mem_wstrb = 4'h0;
      #1;
      check("abort_ready", 64'(mem_ready), 64'h0);
    end
    idle_cycle();
    check("abort_err", 64'(bus_err), 64'h0);
    run_txn(32'h0000_2044, 4'h0, 0);

    // Reset on what would have been the completion cycle of a char RAM read.
    run_txn(32'h0000_9ABC, 4'h0, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mem_valid = 1'b1;
      mem_addr  = 32'h0000_2000;
      s_ready   = '1;
      #1;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_ready", 64'(mem_ready), 64'h0);
    check("rstmid_sel",   64'(s_sel),     64'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    mem_valid = 1'b0;
    #1;
    exp_err_addr = 32'h0;
    check("rstmid_err_addr", 64'(err_addr),  64'h0);
    check("rstmid_ready2",   64'(mem_ready), 64'h0);
    check("rstmid_rdata",    64'(mem_rdata), 64'h0);
    run_txn(32'h0000_2000, 4'h0, 0);

    for (int k = 0; k < 60; k++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[15:12] = 4'($urandom_range(0, 5));
      run_txn(a, 4'($urandom), $urandom_range(0, 8));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
